// File: rtl/align_accum_pkg.sv
// Shared MAC definitions: operand widths and the align_accum state encoding.
package align_accum_pkg;

    localparam int PP_W  = 14;
    localparam int EXP_W = 6;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ACCUM_ENC = 2'd1;
    localparam logic [1:0] ST_HOLD_ENC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ACCUM = ST_ACCUM_ENC,
        ST_HOLD  = ST_HOLD_ENC
    } state_t;

endpackage

// File: rtl/sm_to_tc.sv
// Sign-magnitude to two's-complement converter, zero-extending the magnitude to ACC_W.
module sm_to_tc
    import align_accum_pkg::*;
#(
    parameter int ACC_W = 19
) (
    input  logic [PP_W-1:0]  mag,
    input  logic             sign,
    output logic [ACC_W-1:0] tc
);

    logic [ACC_W-1:0] mag_ext;

    // Negating a zero magnitude yields zero, so "-0" needs no special case.
    assign mag_ext = {{(ACC_W - PP_W){1'b0}}, mag};
    assign tc      = sign ? (-mag_ext) : mag_ext;

endmodule

// File: rtl/align_accum.sv
// Accumulates a group of aligned sign-magnitude partial products into one
// two's-complement sum and hands it to the normaliser over valid/ready.
module align_accum
    import align_accum_pkg::*;
#(
    parameter int MAX_TERMS = 16,
    parameter int ACC_W     = 19,
    parameter int CNT_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [PP_W-1:0]  shifted_unsign_pp,
    input  logic             pp_sign,
    input  logic [EXP_W-1:0] max_exp,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] acc_sum,
    output logic [EXP_W-1:0] acc_exp,
    output logic [CNT_W-1:0] acc_terms,
    output logic             exp_mismatch,
    output logic             forced_close
);

    // Handshake: a transfer happens on a rising edge where valid && ready are
    // both high; valid and its payload stay stable until that edge.

    state_t           state;
    logic [ACC_W-1:0] term;
    logic [CNT_W-1:0] next_cnt;
    logic             reach_max;
    logic             accept;

    sm_to_tc #(.ACC_W(ACC_W)) u_sm_to_tc (
        .mag  (shifted_unsign_pp),
        .sign (pp_sign),
        .tc   (term)
    );

    assign accept    = in_valid && in_ready;
    assign next_cnt  = acc_terms + CNT_W'(1);
    assign reach_max = (next_cnt == CNT_W'(MAX_TERMS));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_IDLE;
            in_ready     <= 1'b0;
            out_valid    <= 1'b0;
            acc_sum      <= '0;
            acc_exp      <= '0;
            acc_terms    <= '0;
            exp_mismatch <= 1'b0;
            forced_close <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    // in_ready is low for the first cycle out of reset.
                    in_ready <= 1'b1;
                    if (accept) begin
                        acc_sum      <= term;
                        acc_terms    <= CNT_W'(1);
                        acc_exp      <= max_exp;
                        exp_mismatch <= 1'b0;
                        forced_close <= 1'b0;
                        if (in_last || (MAX_TERMS == 1)) begin
                            state     <= ST_HOLD;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                        end else begin
                            state <= ST_ACCUM;
                        end
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        acc_sum   <= acc_sum + term;
                        acc_terms <= next_cnt;
                        if (max_exp != acc_exp) begin
                            exp_mismatch <= 1'b1;
                        end
                        if (in_last || reach_max) begin
                            state        <= ST_HOLD;
                            in_ready     <= 1'b0;
                            out_valid    <= 1'b1;
                            forced_close <= !in_last;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_ready) begin
                        state     <= ST_IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_align_accum.sv
// Randomized scoreboard bench for align_accum with a queue-based group model.
module tb_align_accum;
    import align_accum_pkg::*;

    localparam int MAX_TERMS = 16;
    localparam int ACC_W     = 19;
    localparam int CNT_W     = 5;
    localparam int PK_W      = ACC_W + EXP_W + CNT_W + 2;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [PP_W-1:0]  shifted_unsign_pp;
    logic             pp_sign;
    logic [EXP_W-1:0] max_exp;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] acc_sum;
    logic [EXP_W-1:0] acc_exp;
    logic [CNT_W-1:0] acc_terms;
    logic             exp_mismatch;
    logic             forced_close;

    logic [PK_W-1:0]  exp_q[$];
    logic [PK_W-1:0]  last_exp;
    logic [PK_W-1:0]  mon_e;
    int               terms_q[$];
    logic [EXP_W-1:0] grp_exp;
    bit               grp_mm;
    bit               rand_rdy;
    int               checks;
    int               errors;

    align_accum #(.MAX_TERMS(MAX_TERMS), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .shifted_unsign_pp (shifted_unsign_pp),
        .pp_sign           (pp_sign),
        .max_exp           (max_exp),
        .in_last           (in_last),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .acc_sum           (acc_sum),
        .acc_exp           (acc_exp),
        .acc_terms         (acc_terms),
        .exp_mismatch      (exp_mismatch),
        .forced_close      (forced_close)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference model: a group is a list of signed integer terms summed at close.
    function automatic logic [PK_W-1:0] close_group(input bit last);
        int sum = 0;
        foreach (terms_q[i]) sum += terms_q[i];
        return {ACC_W'(sum), grp_exp, CNT_W'(terms_q.size()), grp_mm, !last};
    endfunction

    // Driver tasks: called at a falling edge, return at a falling edge.
    task automatic send(input logic [PP_W-1:0] mag, input logic s,
                        input logic [EXP_W-1:0] e, input logic last);
        int guard = 0;
        bit closed;
        in_valid = 1'b1;
        shifted_unsign_pp = mag;
        pp_sign = s;
        max_exp = e;
        in_last = last;
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            check("accept_timeout", 32'(in_ready), 1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (terms_q.size() == 0) begin
            grp_exp = e;
            grp_mm  = 1'b0;
        end else if (e != grp_exp) begin
            grp_mm = 1'b1;
        end
        terms_q.push_back(s ? -int'(mag) : int'(mag));
        closed = last || (terms_q.size() == MAX_TERMS);
        if (closed) begin
            last_exp = close_group(last);
            exp_q.push_back(last_exp);
            terms_q.delete();
        end
        @(negedge clk);
        if (closed) check("valid_latency", 32'(out_valid), 1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ready(input logic v);
        @(posedge clk);
        #1;
        out_ready = v;
        @(negedge clk);
    endtask

    always begin
        @(posedge clk);
        #1;
        if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
    end

    // Scoreboard monitor: compares each result on the cycle it is taken.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("acc_sum",      32'(acc_sum),      32'(mon_e[31:13]));
                check("acc_exp",      32'(acc_exp),      32'(mon_e[12:7]));
                check("acc_terms",    32'(acc_terms),    32'(mon_e[6:2]));
                check("exp_mismatch", 32'(exp_mismatch), 32'(mon_e[1]));
                check("forced_close", 32'(forced_close), 32'(mon_e[0]));
            end
        end
    end

    initial begin
        int guard;
        int len;
        bit forced;
        logic [EXP_W-1:0] e0;
        checks = 0;
        errors = 0;
        rand_rdy = 1'b0;
        rst = 1'b1;
        in_valid = 1'b0;
        shifted_unsign_pp = '0;
        pp_sign = 1'b0;
        max_exp = '0;
        in_last = 1'b0;
        out_ready = 1'b1;

        #12;
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_out_valid", 32'(out_valid), 0);
        check("rst_acc_sum",   32'(acc_sum),   0);
        check("rst_acc_terms", 32'(acc_terms), 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(in_ready), 1);

        // Three-term group with mixed signs
        send(14'h2000, 1'b0, 6'd5, 1'b0);
        send(14'h0100, 1'b0, 6'd5, 1'b0);
        send(14'h0040, 1'b1, 6'd5, 1'b1);
        check("t1_sum", 32'(acc_sum), 32'h0000_20C0);
        idle(2);

        // Sixteen max-magnitude negatives force the group closed
        for (int i = 0; i < MAX_TERMS; i++) send(14'd16383, 1'b1, 6'd3, 1'b0);
        check("t2_sum",    32'(acc_sum),      32'h0004_0010);
        check("t2_forced", 32'(forced_close), 1);
        check("t2_terms",  32'(acc_terms),    16);
        idle(2);

        // Exponent mismatch inside a group
        send(14'd100, 1'b0, 6'd7, 1'b0);
        send(14'd200, 1'b0, 6'd7, 1'b0);
        send(14'd50,  1'b1, 6'd6, 1'b1);
        check("t3_mismatch", 32'(exp_mismatch), 1);
        check("t3_exp",      32'(acc_exp),      7);
        idle(2);

        // Negative zero as a one-term group
        send(14'd0, 1'b1, 6'd9, 1'b1);
        check("t6_sum",   32'(acc_sum),   0);
        check("t6_terms", 32'(acc_terms), 1);
        idle(2);

        // Back-pressure in HOLD with a product waiting upstream
        set_ready(1'b0);
        send(14'd10, 1'b0, 6'd2, 1'b0);
        send(14'd20, 1'b0, 6'd2, 1'b1);
        in_valid = 1'b1;
        shifted_unsign_pp = 14'd777;
        pp_sign = 1'b0;
        max_exp = 6'd2;
        in_last = 1'b1;
        repeat (5) begin
            check("hold_in_ready",  32'(in_ready),  0);
            check("hold_out_valid", 32'(out_valid), 1);
            check("hold_acc_sum",   32'(acc_sum),   32'(last_exp[31:13]));
            check("hold_acc_terms", 32'(acc_terms), 32'(last_exp[6:2]));
            @(negedge clk);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        set_ready(1'b1);
        send(14'd777, 1'b0, 6'd2, 1'b1);
        idle(2);

        // Asynchronous reset in the middle of a group
        for (int i = 0; i < 4; i++) send(14'(100 * (i + 1)), 1'b0, 6'd4, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 0);
        check("mid_rst_acc_terms", 32'(acc_terms), 0);
        check("mid_rst_in_ready",  32'(in_ready),  0);
        terms_q.delete();
        @(negedge clk);
        rst = 1'b0;
        send(14'd5, 1'b0, 6'd1, 1'b0);
        send(14'd6, 1'b1, 6'd1, 1'b1);
        check("post_rst_sum", 32'(acc_sum), 32'(19'h7FFFF));
        idle(2);

        // Random groups with random back-pressure and idle gaps
        rand_rdy = 1'b1;
        for (int g = 0; g < 40; g++) begin
            len    = $urandom_range(1, MAX_TERMS);
            forced = (len == MAX_TERMS) && ($urandom_range(0, 1) == 1);
            e0     = 6'($urandom_range(0, 63));
            for (int k = 0; k < len; k++) begin
                send(14'($urandom_range(0, 16383)), 1'($urandom_range(0, 1)),
                     ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : e0,
                     (k == len - 1) && !forced);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            end
        end
        rand_rdy = 1'b0;
        set_ready(1'b1);

        guard = 0;
        while (exp_q.size() > 0 && guard < 500) begin
            @(negedge clk);
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
